// File: rtl/video_gen_grid.sv
// NxN tile-board renderer: shadow/display tile matrices with frame-start commit,
// grid geometry decode, change flash and game-mode overlay; RGB two cycles after x/y.
module video_gen_grid #(
  parameter int GRID_N       = 4,
  parameter int VAL_W        = 12,
  parameter int CELL_PX      = 96,
  parameter int GRID_LINE    = 4,
  parameter int ORIGIN_X     = 120,
  parameter int ORIGIN_Y     = 40,
  parameter int FLASH_FRAMES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  input  logic             frame_start,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [2:0]       upd_row,
  input  logic [2:0]       upd_col,
  input  logic [VAL_W-1:0] upd_val,
  input  logic [1:0]       mode,
  output logic [7:0]       r,
  output logic [7:0]       g,
  output logic [7:0]       b
);
  localparam int P    = CELL_PX + GRID_LINE;
  localparam int SPAN = GRID_N * P + GRID_LINE;
  localparam int IW   = $clog2(GRID_N);
  localparam int FW   = $clog2(FLASH_FRAMES + 1);
  localparam int CW   = 12;

  typedef logic [GRID_N-1:0][GRID_N-1:0][VAL_W-1:0] mat_t;
  typedef logic [GRID_N-1:0][GRID_N-1:0]            msk_t;

  typedef struct packed {
    logic       line;
    logic [3:0] idx;
  } axis_t;

  mat_t          shadow, display;
  msk_t          mask, diff;
  logic [FW-1:0] flash;
  logic          rdy;

  assign upd_ready = rdy & ~frame_start;

  always_comb begin
    diff = '0;
    for (int i = 0; i < GRID_N; i++)
      for (int j = 0; j < GRID_N; j++)
        diff[i][j] = (display[i][j] != shadow[i][j]);
  end

  // The mask is only replaced by a commit that changes something, so a flash
  // keeps highlighting its tiles while the counter runs down on idle frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      display <= '0;
      mask    <= '0;
      flash   <= '0;
      rdy     <= 1'b0;
    end else begin
      rdy <= 1'b1;
      if (upd_valid && upd_ready && ({1'b0, upd_row} < 4'(GRID_N)) &&
          ({1'b0, upd_col} < 4'(GRID_N)))
        shadow[upd_row[IW-1:0]][upd_col[IW-1:0]] <= upd_val;
      if (frame_start) begin
        display <= shadow;
        if (|diff) begin
          mask  <= diff;
          flash <= FW'(FLASH_FRAMES);
        end else if (flash != '0) begin
          flash <= flash - FW'(1);
        end
      end
    end
  end

  // Offset-to-cell decode by constant threshold compares instead of a divider.
  function automatic axis_t decode(input logic [CW-1:0] d);
    axis_t         a;
    logic [CW-1:0] off;
    a.idx = '0;
    off   = d;
    for (int i = 1; i <= GRID_N; i++)
      if (d >= CW'(i * P)) begin
        a.idx = 4'(i);
        off   = d - CW'(i * P);
      end
    a.line = (off < CW'(GRID_LINE)) || (a.idx == 4'(GRID_N));
    return a;
  endfunction

  logic [CW-1:0] xe, ye;
  axis_t         ax, ay;
  logic          in_grid;
  logic [VAL_W-1:0] tval;
  logic          tflash;

  always_comb begin
    xe      = CW'(x);
    ye      = CW'(y);
    in_grid = (xe >= CW'(ORIGIN_X)) && (xe < CW'(ORIGIN_X + SPAN)) &&
              (ye >= CW'(ORIGIN_Y)) && (ye < CW'(ORIGIN_Y + SPAN));
    ax      = decode(xe - CW'(ORIGIN_X));
    ay      = decode(ye - CW'(ORIGIN_Y));
    tval    = display[ay.idx[IW-1:0]][ax.idx[IW-1:0]];
    tflash  = (flash != '0) && mask[ay.idx[IW-1:0]][ax.idx[IW-1:0]];
  end

  // Stage 1: geometry, mode and tile lookup, so a commit is seen from the next pixel on.
  logic             s1_in, s1_line, s1_flash;
  logic [1:0]       s1_mode;
  logic [VAL_W-1:0] s1_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_in    <= 1'b0;
      s1_line  <= 1'b0;
      s1_flash <= 1'b0;
      s1_mode  <= '0;
      s1_val   <= '0;
    end else begin
      s1_in    <= in_grid;
      s1_line  <= ax.line | ay.line;
      s1_flash <= tflash;
      s1_mode  <= mode;
      s1_val   <= tval;
    end
  end

  logic [7:0]  k;
  logic [23:0] col;

  always_comb begin
    k = '0;
    for (int i = 0; i < VAL_W; i++)
      if (s1_val[i]) k = 8'(i);
    col = 24'h000000;
    if (s1_in) begin
      if (s1_line)                 col = 24'hFFFFFF;
      else if (s1_mode == 2'd1)    col = 24'hC0C0C0;
      else if (s1_flash)           col = 24'hFFFFFF;
      else if (s1_val == '0)       col = 24'hC0C0C0;
      else                         col = {8'hFF, 8'hFF - (k << 4), 8'h20};
      if (s1_mode == 2'd2) col[15:8] = 8'hFF;
    end
    if (s1_mode == 2'd3)
      col = {1'b0, col[23:17], 1'b0, col[15:9], 1'b0, col[7:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
      g <= '0;
      b <= '0;
    end else begin
      r <= col[23:16];
      g <= col[15:8];
      b <= col[7:0];
    end
  end
endmodule

// File: tb/tb_video_gen_grid.sv
// Self-checking bench for video_gen_grid: directed scenarios plus randomized
// writes/pixels against a divide/modulo reference model of the board.
module tb_video_gen_grid;
  localparam int N = 4, P = 100, L = 4, OX = 120, OY = 40, FL = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] x, y;
  logic       frame_start, upd_valid, upd_ready;
  logic [2:0] upd_row, upd_col;
  logic [11:0] upd_val;
  logic [1:0] mode;
  logic [7:0] r, g, b;

  always #5 clk = ~clk;

  video_gen_grid dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .frame_start(frame_start),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_row(upd_row),
    .upd_col(upd_col), .upd_val(upd_val), .mode(mode), .r(r), .g(g), .b(b)
  );

  int checks = 0, errors = 0;
  int m_sh[8][8], m_dp[8][8];
  bit m_mk[8][8];
  int m_fl;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] ref_rgb(input int px, input int py, input int md);
    int span, dx, dy, cc, rr, v;
    bit ing, line;
    logic [7:0] cr, cg, cb;
    span = N * P + L;
    ing = px >= OX && px < OX + span && py >= OY && py < OY + span;
    cr = 0; cg = 0; cb = 0;
    if (ing) begin
      dx = px - OX; dy = py - OY; cc = dx / P; rr = dy / P;
      line = (dx % P < L) || (dy % P < L) || cc == N || rr == N;
      if (line) begin cr = 8'hFF; cg = 8'hFF; cb = 8'hFF; end
      else if (md == 1) begin cr = 8'hC0; cg = 8'hC0; cb = 8'hC0; end
      else begin
        v = m_dp[rr][cc];
        if (m_fl > 0 && m_mk[rr][cc]) begin cr = 8'hFF; cg = 8'hFF; cb = 8'hFF; end
        else if (v == 0) begin cr = 8'hC0; cg = 8'hC0; cb = 8'hC0; end
        else begin cr = 8'hFF; cg = 8'(255 - 16 * $clog2(v)); cb = 8'h20; end
      end
      if (md == 2) cg = 8'hFF;
    end
    if (md == 3) begin cr = cr >> 1; cg = cg >> 1; cb = cb >> 1; end
    return {cr, cg, cb};
  endfunction

  task automatic model_commit;
    bit any = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (m_dp[i][j] != m_sh[i][j]) any = 1;
    if (any) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          m_mk[i][j] = (m_dp[i][j] != m_sh[i][j]);
      m_fl = FL;
    end else if (m_fl > 0) m_fl--;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        m_dp[i][j] = m_sh[i][j];
  endtask

  task automatic model_clear;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        m_sh[i][j] = 0; m_dp[i][j] = 0; m_mk[i][j] = 0;
      end
    m_fl = 0;
  endtask

  task automatic frame;
    frame_start = 1'b1;
    #1;
    checks++;
    if (upd_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_frame_start: got %b expected 0", upd_ready);
    end
    tick();
    frame_start = 1'b0;
    model_commit();
  endtask

  task automatic wr(input int row, input int col, input int val);
    upd_valid = 1'b1; upd_row = 3'(row); upd_col = 3'(col); upd_val = 12'(val);
    #1;
    checks++;
    if (upd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_idle: got %b expected 1", upd_ready);
    end
    tick();
    upd_valid = 1'b0;
    if (row < N && col < N) m_sh[row][col] = val;
  endtask

  task automatic chk_pix(input int px, input int py, input logic [23:0] exp, input string nm);
    x = 10'(px); y = 10'(py);
    tick(); tick();
    checks++;
    if ({r, g, b} !== exp) begin
      errors++;
      $display("FAIL %s (%0d,%0d): got %06h expected %06h", nm, px, py, {r, g, b}, exp);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; x = 10'd150; y = 10'd60; mode = 2'd0;
    frame_start = 1'b0; upd_valid = 1'b0; upd_row = '0; upd_col = '0; upd_val = '0;
    model_clear();
    tick(); tick();
    checks++;
    if ({r, g, b} !== 24'h0 || upd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rgb=%06h ready=%b expected 000000/0", {r, g, b}, upd_ready);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (upd_ready !== 1'b1 || {r, g, b} !== 24'h0) begin
      errors++;
      $display("FAIL reset_release_1: got rgb=%06h ready=%b expected 000000/1", {r, g, b}, upd_ready);
    end
    tick();
    checks++;
    if ({r, g, b} !== 24'hC0C0C0) begin
      errors++;
      $display("FAIL reset_release_2: got %06h expected c0c0c0", {r, g, b});
    end
  endtask

  task automatic test_flash;
    wr(0, 0, 2);
    chk_pix(150, 60, 24'hC0C0C0, "pre_commit");
    frame();
    chk_pix(150, 60, 24'hFFFFFF, "flash_start");
    repeat (7) begin
      frame();
      chk_pix(150, 60, 24'hFFFFFF, "flash_hold");
    end
    frame();
    chk_pix(150, 60, 24'hFFEF20, "flash_end");
  endtask

  task automatic test_write_across_frame;
    upd_valid = 1'b1; upd_row = 3'd3; upd_col = 3'd3; upd_val = 12'd2048;
    frame_start = 1'b1;
    #1;
    checks++;
    if (upd_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_block: got %b expected 0", upd_ready);
    end
    tick();
    frame_start = 1'b0;
    model_commit();
    #1;
    checks++;
    if (upd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after: got %b expected 1", upd_ready);
    end
    tick();
    upd_valid = 1'b0;
    m_sh[3][3] = 2048;
    chk_pix(500, 420, 24'hC0C0C0, "held_write_pending");
    frame();
    chk_pix(500, 420, 24'hFFFFFF, "flash_2048");
    repeat (8) frame();
    chk_pix(500, 420, 24'hFF4F20, "tile_2048");
    chk_pix(150, 60, 24'hFFEF20, "tile_2_kept");
  endtask

  task automatic test_geometry;
    chk_pix(120, 60, 24'hFFFFFF, "left_line");
    chk_pix(523, 60, 24'hFFFFFF, "right_line");
    chk_pix(524, 60, 24'h000000, "right_outside");
    chk_pix(119, 60, 24'h000000, "left_outside");
    chk_pix(150, 40, 24'hFFFFFF, "top_line");
    chk_pix(150, 524, 24'h000000, "bottom_outside");
  endtask

  task automatic test_modes;
    wr(0, 0, 0);
    frame();
    repeat (8) frame();
    mode = 2'd3; chk_pix(150, 60, 24'h606060, "mode3_empty");
    mode = 2'd2; chk_pix(150, 60, 24'hC0FFC0, "mode2_empty");
    mode = 2'd1; chk_pix(500, 420, 24'hC0C0C0, "mode1_2048");
    mode = 2'd3; chk_pix(500, 420, 24'h7F2710, "mode3_2048");
    mode = 2'd2; chk_pix(524, 60, 24'h000000, "mode2_outside");
    mode = 2'd0;
  endtask

  task automatic test_random;
    logic [23:0] exp[$];
    int n, row, col, val;
    for (int round = 0; round < 5; round++) begin
      repeat (6) begin
        row = $urandom_range(0, 7); col = $urandom_range(0, 5);
        val = ($urandom_range(0, 3) == 0) ? 0 : (1 << $urandom_range(1, 11));
        wr(row, col, val);
      end
      frame();
      repeat ($urandom_range(0, 9)) frame();
      exp.delete();
      n = 60;
      for (int i = 0; i <= n; i++) begin
        if (i < n) begin
          x = 10'($urandom_range(100, 545));
          y = 10'($urandom_range(20, 545));
          mode = 2'($urandom_range(0, 3));
          exp.push_back(ref_rgb(int'(x), int'(y), int'(mode)));
        end
        tick();
        if (i >= 1) begin
          checks++;
          if ({r, g, b} !== exp[i-1]) begin
            errors++;
            $display("FAIL random_pixel #%0d round %0d: got %06h expected %06h", i - 1, round, {r, g, b}, exp[i-1]);
          end
        end
      end
      mode = 2'd0;
    end
  endtask

  task automatic test_mid_reset;
    wr(1, 2, 64);
    wr(2, 1, 1024);
    frame();
    chk_pix(120, 60, 24'hFFFFFF, "pre_reset_line");
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({r, g, b} !== 24'h0 || upd_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got rgb=%06h ready=%b expected 000000/0", {r, g, b}, upd_ready);
    end
    model_clear();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    frame();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk_pix(OX + L + j * P + 48, OY + L + i * P + 48, 24'hC0C0C0, "post_reset_tile");
  endtask

  initial begin
    test_reset();
    test_flash();
    test_write_across_frame();
    test_geometry();
    test_modes();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
